// File: rtl/rot_pkg.sv
// Shared widths and the request record for the rotate-request FIFO.
package rot_pkg;

    localparam int ROT_W = 32;
    localparam int AMT_W = 5;
    localparam int REQ_W = ROT_W + AMT_W;

    // One buffered rotate request: operand plus rotate amount.
    typedef struct packed {
        logic [ROT_W-1:0] data;
        logic [AMT_W-1:0] amt;
    } rot_req_t;

endpackage : rot_pkg

// File: rtl/rot_req_fifo_if.sv
// Producer/consumer handshake bundle of the rotate-request FIFO.
interface rot_req_fifo_if
    import rot_pkg::*;
#(
    parameter int DEPTH = 4
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ROT_W-1:0] in_data_i;
    logic [AMT_W-1:0] in_amt_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [ROT_W-1:0] out_data_o;
    logic [AMT_W-1:0] out_amt_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [CNT_W-1:0] count_o;

    // Environment side: offers requests and takes the head entry.
    modport master (
        output in_data_i,
        output in_amt_i,
        output in_valid_i,
        input  in_ready_o,
        input  out_data_o,
        input  out_amt_o,
        input  out_valid_o,
        output out_ready_i,
        input  count_o
    );

    // FIFO side.
    modport slave (
        input  in_data_i,
        input  in_amt_i,
        input  in_valid_i,
        output in_ready_o,
        output out_data_o,
        output out_amt_o,
        output out_valid_o,
        input  out_ready_i,
        output count_o
    );

endinterface : rot_req_fifo_if

// File: rtl/rot_req_mem.sv
// Register file holding the buffered requests: synchronous write,
// combinational read. Contents are not reset; the FIFO masks its
// outputs whenever no valid entry is present.
module rot_req_mem
    import rot_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  rot_req_t                 wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output rot_req_t                 rdata_o
);

    rot_req_t mem_q [DEPTH];
    rot_req_t mem_d [DEPTH];

    // Next array contents: only the addressed slot changes on a write.
    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    // Storage register; deliberately without reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : rot_req_mem

// File: rtl/rot_req_fifo.sv
// First-word-fall-through FIFO of rotate requests feeding a rotator.
// Holds read/write pointers and occupancy; storage lives in rot_req_mem.
// Ready/valid are pure functions of the registered count, so neither
// depends combinationally on the opposite side's handshake.
module rot_req_fifo
    import rot_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    rot_req_fifo_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic     in_ready;
    logic     out_valid;
    logic     push;
    logic     pop;
    rot_req_t wr_req;
    rot_req_t head;

    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign push      = bus.in_valid_i && in_ready;
    assign pop       = out_valid && bus.out_ready_i;

    assign wr_req.data = bus.in_data_i;
    assign wr_req.amt  = bus.in_amt_i;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_ONE;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset discards every buffered entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    rot_req_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wptr_q),
        .wdata_i (wr_req),
        .raddr_i (rptr_q),
        .rdata_o (head)
    );

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.out_data_o  = out_valid ? head.data : '0;
    assign bus.out_amt_o   = out_valid ? head.amt  : '0;
    assign bus.count_o     = count_q;

endmodule : rot_req_fifo

// File: tb/tb_rot_req_fifo.sv
// Self-checking bench for rot_req_fifo against a queue-based model.
module tb_rot_req_fifo;
    import rot_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    rot_req_t mq[$];

    rot_req_fifo_if #(.DEPTH(DEPTH)) bus ();

    rot_req_fifo #(
        .DEPTH (DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; the model applies the FIFO rules to the inputs
    // driven before the edge. Outputs are then stable at #1 after the edge.
    task automatic cycle();
        bit do_push;
        bit do_pop;
        rot_req_t r;
        do_push = bus.in_valid_i && (mq.size() < DEPTH);
        do_pop  = bus.out_ready_i && (mq.size() != 0);
        r.data  = bus.in_data_i;
        r.amt   = bus.in_amt_i;
        @(posedge clk);
        if (rst) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(r);
        end
        #1;
    endtask

    task automatic drive_idle();
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.in_amt_i    = '0;
        bus.out_ready_i = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] d, input logic [4:0] a);
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = d;
        bus.in_amt_i   = a;
        cycle();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) cycle();
        bus.out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        checks++;
        if (bus.count_o !== 3'd0 || bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got cnt=%0d vld=%b rdy=%b exp cnt=0 vld=0 rdy=1",
                     bus.count_o, bus.out_valid_o, bus.in_ready_o);
        end
        checks++;
        if (bus.out_data_o !== 32'h0 || bus.out_amt_o !== 5'd0) begin
            errors++;
            $display("FAIL reset_mask got data=%h amt=%0d exp 0/0", bus.out_data_o, bus.out_amt_o);
        end
    endtask

    task automatic test_first_push();
        push_one(32'h0000_0001, 5'd4);
        checks++;
        if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'h1 || bus.out_amt_o !== 5'd4
            || bus.count_o !== 3'd1) begin
            errors++;
            $display("FAIL first_push got vld=%b data=%h amt=%0d cnt=%0d exp 1/00000001/4/1",
                     bus.out_valid_o, bus.out_data_o, bus.out_amt_o, bus.count_o);
        end
        drain();
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 4; i++) push_one(32'hA0 + i, 5'(i));
        checks++;
        if (bus.count_o !== 3'd4 || bus.in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full_state got cnt=%0d rdy=%b exp 4/0", bus.count_o, bus.in_ready_o);
        end
        push_one(32'hA4, 5'd9);
        checks++;
        if (bus.count_o !== 3'd4 || bus.out_data_o !== 32'hA0) begin
            errors++;
            $display("FAIL overflow_ignored got cnt=%0d head=%h exp 4/a0", bus.count_o, bus.out_data_o);
        end
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'hA0 + i || bus.out_amt_o !== 5'(i)) begin
                errors++;
                $display("FAIL pop_order[%0d] got vld=%b data=%h amt=%0d exp 1/%h/%0d",
                         i, bus.out_valid_o, bus.out_data_o, bus.out_amt_o, 32'hA0 + i, i);
            end
            cycle();
        end
        bus.out_ready_i = 1'b0;
        checks++;
        if (bus.count_o !== 3'd0 || bus.out_valid_o !== 1'b0 || bus.out_data_o !== 32'h0) begin
            errors++;
            $display("FAIL drained got cnt=%0d vld=%b data=%h exp 0/0/0",
                     bus.count_o, bus.out_valid_o, bus.out_data_o);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) push_one(32'h10 + i, 5'(i + 8));
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = 32'hB0;
        bus.in_amt_i    = 5'd1;
        bus.out_ready_i = 1'b1;
        #1;
        checks++;
        if (bus.in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full_refuse_rdy got %b exp 0", bus.in_ready_o);
        end
        cycle();
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        checks++;
        if (bus.count_o !== 3'd3 || bus.in_ready_o !== 1'b1 || bus.out_data_o !== 32'h11) begin
            errors++;
            $display("FAIL full_pop got cnt=%0d rdy=%b head=%h exp 3/1/11",
                     bus.count_o, bus.in_ready_o, bus.out_data_o);
        end
        bus.out_ready_i = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (bus.out_data_o !== 32'h10 + i || bus.out_amt_o !== 5'(i + 8)) begin
                errors++;
                $display("FAIL full_rest[%0d] got data=%h amt=%0d exp %h/%0d",
                         i, bus.out_data_o, bus.out_amt_o, 32'h10 + i, i + 8);
            end
            cycle();
        end
        bus.out_ready_i = 1'b0;
        checks++;
        if (bus.out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL b0_not_stored got vld=%b data=%h exp 0", bus.out_valid_o, bus.out_data_o);
        end
    endtask

    task automatic test_stream_wrap();
        push_one(32'hC0, 5'd0);
        bus.out_ready_i = 1'b1;
        for (int i = 1; i < 10; i++) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = 32'hC0 + i;
            bus.in_amt_i   = 5'(i);
            checks++;
            if (bus.out_data_o !== 32'hC0 + i - 1 || bus.out_amt_o !== 5'(i - 1)) begin
                errors++;
                $display("FAIL stream_head[%0d] got data=%h amt=%0d exp %h/%0d",
                         i, bus.out_data_o, bus.out_amt_o, 32'hC0 + i - 1, i - 1);
            end
            cycle();
            checks++;
            if (bus.count_o !== 3'd1) begin
                errors++;
                $display("FAIL stream_count[%0d] got %0d exp 1", i, bus.count_o);
            end
        end
        bus.in_valid_i = 1'b0;
        checks++;
        if (bus.out_data_o !== 32'hC9) begin
            errors++;
            $display("FAIL stream_last got %h exp c9", bus.out_data_o);
        end
        cycle();
        bus.out_ready_i = 1'b0;
        checks++;
        if (bus.count_o !== 3'd0) begin
            errors++;
            $display("FAIL stream_empty got %0d exp 0", bus.count_o);
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 3; i++) push_one(32'hD0 + i, 5'(i));
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 32'hDD;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.in_valid_i = 1'b0;
        checks++;
        if (bus.count_o !== 3'd0 || bus.out_valid_o !== 1'b0 || bus.out_data_o !== 32'h0
            || bus.out_amt_o !== 5'd0 || bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_flush got cnt=%0d vld=%b data=%h amt=%0d rdy=%b exp 0/0/0/0/1",
                     bus.count_o, bus.out_valid_o, bus.out_data_o, bus.out_amt_o, bus.in_ready_o);
        end
    endtask

    task automatic test_empty_no_bypass();
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = 32'hFFFF_FFFF;
        bus.in_amt_i    = 5'd31;
        bus.out_ready_i = 1'b1;
        #1;
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.out_data_o !== 32'h0) begin
            errors++;
            $display("FAIL empty_bypass got vld=%b data=%h exp 0/0", bus.out_valid_o, bus.out_data_o);
        end
        cycle();
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        checks++;
        if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'hFFFF_FFFF || bus.out_amt_o !== 5'd31
            || bus.count_o !== 3'd1) begin
            errors++;
            $display("FAIL empty_push got vld=%b data=%h amt=%0d cnt=%0d exp 1/ffffffff/31/1",
                     bus.out_valid_o, bus.out_data_o, bus.out_amt_o, bus.count_o);
        end
        drain();
    endtask

    task automatic test_random();
        logic [31:0] exp_data;
        logic [4:0]  exp_amt;
        for (int n = 0; n < 400; n++) begin
            bus.in_valid_i  = ($urandom_range(0, 3) != 0);
            bus.out_ready_i = ($urandom_range(0, 2) == 0);
            bus.in_data_i   = $urandom;
            bus.in_amt_i    = 5'($urandom_range(0, 31));
            rst             = ($urandom_range(0, 79) == 0);
            cycle();
            rst = 1'b0;
            exp_data = (mq.size() != 0) ? mq[0].data : 32'h0;
            exp_amt  = (mq.size() != 0) ? mq[0].amt  : 5'd0;
            checks++;
            if (bus.count_o !== 3'(mq.size()) || bus.out_valid_o !== (mq.size() != 0)
                || bus.in_ready_o !== (mq.size() < DEPTH)) begin
                errors++;
                $display("FAIL rand_ctrl[%0d] got cnt=%0d vld=%b rdy=%b exp cnt=%0d",
                         n, bus.count_o, bus.out_valid_o, bus.in_ready_o, mq.size());
            end
            checks++;
            if (bus.out_data_o !== exp_data || bus.out_amt_o !== exp_amt) begin
                errors++;
                $display("FAIL rand_head[%0d] got data=%h amt=%0d exp %h/%0d",
                         n, bus.out_data_o, bus.out_amt_o, exp_data, exp_amt);
            end
        end
        drive_idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        drive_idle();
        @(negedge clk);
        test_reset();
        test_first_push();
        test_fill_overflow();
        test_full_push_pop();
        test_stream_wrap();
        test_reset_midflight();
        test_empty_no_bypass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rot_req_fifo
